// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - two-stage signed 16x8 / dual 8x8 radix-4 Booth multiplier
module arithmetic_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    input  logic        mode,
    output logic [31:0] p
);

    logic [15:0] x_q;
    logic [7:0]  y_q;
    logic        mode_q;
    logic [31:0] p_q, p_d;

    logic [23:0] prod_wide;
    logic [15:0] prod_hi, prod_lo;

    // One Booth partial product of a 24-bit sign-extended multiplicand.
    function automatic logic [23:0] booth_pp24(input logic [23:0] a, input logic [2:0] trip);
        logic [23:0] pp;
        pp = 24'd0;
        case (trip)
            3'b001, 3'b010: pp = a;
            3'b011:         pp = a << 1;
            3'b100:         pp = ~(a << 1) + 24'd1;
            3'b101, 3'b110: pp = ~a + 24'd1;
            default:        pp = 24'd0;
        endcase
        return pp;
    endfunction

    function automatic logic [15:0] booth_pp16(input logic [15:0] a, input logic [2:0] trip);
        logic [15:0] pp;
        pp = 16'd0;
        case (trip)
            3'b001, 3'b010: pp = a;
            3'b011:         pp = a << 1;
            3'b100:         pp = ~(a << 1) + 16'd1;
            3'b101, 3'b110: pp = ~a + 16'd1;
            default:        pp = 16'd0;
        endcase
        return pp;
    endfunction

    function automatic logic [23:0] booth_mul16x8(input logic [15:0] a, input logic [7:0] b);
        logic [23:0] acc;
        logic [23:0] a_ext;
        logic [8:0]  b_ext;
        acc   = 24'd0;
        a_ext = {{8{a[15]}}, a};
        b_ext = {b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            acc = acc + (booth_pp24(a_ext, b_ext[2*i +: 3]) << (2 * i));
        end
        return acc;
    endfunction

    // Each 8x8 lane is accumulated in its own 16-bit space, so no carry or sign
    // extension can cross the bit 15/16 boundary.
    function automatic logic [15:0] booth_mul8x8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        logic [15:0] a_ext;
        logic [8:0]  b_ext;
        acc   = 16'd0;
        a_ext = {{8{a[7]}}, a};
        b_ext = {b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            acc = acc + (booth_pp16(a_ext, b_ext[2*i +: 3]) << (2 * i));
        end
        return acc;
    endfunction

    always_comb begin
        prod_wide = booth_mul16x8(x_q, y_q);
        prod_hi   = booth_mul8x8(x_q[15:8], y_q);
        prod_lo   = booth_mul8x8(x_q[7:0], y_q);
        p_d       = 32'd0;
        if (mode_q) begin
            p_d = {prod_hi, prod_lo};
        end else begin
            p_d = {{8{prod_wide[23]}}, prod_wide};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= 16'd0;
            y_q    <= 8'd0;
            mode_q <= 1'b0;
            p_q    <= 32'd0;
        end else begin
            x_q    <= x;
            y_q    <= y;
            mode_q <= mode;
            p_q    <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb/tb_arithmetic_unit.sv - directed self-checking bench for arithmetic_unit
module tb_arithmetic_unit;

    logic        clk;
    logic        reset;
    logic [15:0] x;
    logic [7:0]  y;
    logic        mode;
    logic [31:0] p;

    int errors;
    int checks;

    typedef struct {
        logic        m;
        logic [15:0] xv;
        logic [7:0]  yv;
        logic [31:0] pv;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] exp_q[$];

    arithmetic_unit dut (
        .clk  (clk),
        .reset(reset),
        .x    (x),
        .y    (y),
        .mode (mode),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: p=%h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic m, input logic [15:0] xv, input logic [7:0] yv);
        logic signed [15:0] xs;
        logic signed [7:0]  xh, xl, ys;
        int full, hi, lo;
        xs   = xv;
        xh   = xv[15:8];
        xl   = xv[7:0];
        ys   = yv;
        full = xs * ys;
        hi   = xh * ys;
        lo   = xl * ys;
        return m ? {hi[15:0], lo[15:0]} : full;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        x      = 16'h0;
        y      = 8'h0;
        mode   = 1'b0;

        vecs[0] = '{1'b0, 16'h0003, 8'h05, 32'h0000_000F};
        vecs[1] = '{1'b0, 16'hFFFF, 8'h02, 32'hFFFF_FFFE};
        vecs[2] = '{1'b0, 16'h8000, 8'h80, 32'h0040_0000};
        vecs[3] = '{1'b1, 16'hFE03, 8'h04, 32'hFFF8_000C};
        vecs[4] = '{1'b0, 16'h7FFF, 8'h7F, 32'h003F_7F81};
        vecs[5] = '{1'b1, 16'h8080, 8'h80, 32'h4000_4000};
        vecs[6] = '{1'b1, 16'h7F80, 8'hFF, 32'hFF81_0080};
        vecs[7] = '{1'b0, 16'h8000, 8'h7F, 32'hFFC0_8000};
        vecs[8] = '{1'b0, 16'h1234, 8'h00, 32'h0000_0000};
        vecs[9] = '{1'b1, 16'hFFFF, 8'hFF, 32'h0001_0001};

        #3;
        check("reset_async", p, 32'h0);
        step();
        step();
        check("reset_held", p, 32'h0);

        #2;
        reset = 1'b1;
        x     = 16'h0003;
        y     = 8'h05;
        mode  = 1'b0;
        step();
        check("post_release_edge1", p, 32'h0);
        x = 16'h0;
        y = 8'h0;
        step();
        check("basic_latency", p, 32'h0000_000F);

        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                mode = vecs[i].m;
                x    = vecs[i].xv;
                y    = vecs[i].yv;
            end
            step();
            if (i >= 1) check($sformatf("directed_%0d", i - 1), p, vecs[i - 1].pv);
        end

        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                mode = i[0];
                x    = 16'($urandom);
                y    = 8'($urandom);
                exp_q.push_back(ref_model(mode, x, y));
            end
            step();
            if (i >= 1) check($sformatf("stream_%0d", i - 1), p, exp_q.pop_front());
        end

        mode = 1'b0;
        x    = 16'h0100;
        y    = 8'h03;
        step();
        mode = 1'b1;
        x    = 16'h0202;
        y    = 8'h05;
        step();
        check("inflight_before_reset", p, 32'h0000_0300);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_op", p, 32'h0);
        step();
        check("reset_mid_op_held", p, 32'h0);
        #2;
        reset = 1'b1;
        mode  = 1'b0;
        x     = 16'hFFFB;
        y     = 8'h03;
        step();
        check("no_stale_after_release", p, 32'h0);
        x = 16'h0;
        y = 8'h0;
        step();
        check("first_after_release", p, 32'hFFFF_FFF1);
        step();
        check("zero_operands", p, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arithmetic_unit.md
ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset: 0 = in reset, 1 = run.
REQ-004 x  input  16  Multiplicand, two's complement.
REQ-005 y  input  8  Multiplier, two's complement.
REQ-006 mode  input  1  Operation select: 0 = single 16x8 multiply, 1 = dual 8x8 multiply.
REQ-007 p  output  32  Registered product.

Function
REQ-008 mode 0 SHALL compute signed x * y as a 24-bit product, sign-extended to 32 bits on p.
REQ-009 mode 1 SHALL compute two independent signed 8x8 products with the shared multiplier y:
- p[15:0] = x[7:0] * y
- p[31:16] = x[15:8] * y
- each product is 16-bit two's complement.
REQ-010 Products SHALL be exact in both modes: no overflow, saturation or rounding.
REQ-011 The datapath SHALL be two stages: x, y and mode are captured in stage-1 registers on rising edge k.
REQ-012 p SHALL show the result of the operands captured at edge k immediately after rising edge k+1 (output register).
- Total latency: two registered stages, fixed.
- No valid/ready handshake.
REQ-013 A new operand set SHALL be accepted every cycle (throughput 1/cycle), and results SHALL emerge in issue order.
REQ-014 mode SHALL be pipelined alongside its operands, so a mode change between consecutive cycles affects only the operation issued with it.
REQ-015 The multiplier SHALL be built from partial products: sign-corrected shift-add or radix-4 Booth encoding of y.
REQ-016 The mode-1 split SHALL suppress carries and sign extension across bit 15/16 so the two lanes are independent.
REQ-017 X/undefined inputs while out of reset are not required to produce defined output; no assertion is required.

Reset
REQ-018 While reset = 0, all pipeline registers SHALL clear asynchronously, without waiting for clk.
- Stage-1 x, y and mode clear to 0.
- p = 32'h0000_0000.
REQ-019 After reset deasserts, p SHALL stay 0 until the first operands captured after release reach the output (two rising edges).
REQ-020 Reset asserted mid-operation SHALL discard all in-flight results; none may appear after release.

Verification
REQ-021 Basic mode 0: mode=0, x=16'h0003, y=8'h05 -> p=32'h0000_000F after two edges.
REQ-022 Sign handling: mode=0, x=16'hFFFF, y=8'h02 -> p=32'hFFFF_FFFE.
REQ-023 Both operands at most-negative: mode=0, x=16'h8000, y=8'h80 -> p=32'h0040_0000.
REQ-024 Dual multiply: mode=1, x=16'hFE03, y=8'h04 -> p=32'hFFF8_000C (lanes -8 and 12).
REQ-025 Back-to-back stream: 16 random x/y pairs, mode toggling every cycle, one new pair per cycle -> each p equals the reference-model product of its operands two edges later, in order.
REQ-026 Reset mid-operation: drive reset low between edges with operands in flight -> p=0 immediately, with no stale result after release; the first new result appears two edges after release.
